// File: rtl/rom_boot_ctrl.sv
// rom_boot_ctrl: boot-time ROM loader.
// Bytes arrive from a loader interface and are packed little-endian into
// 32-bit words, then written to the boot ROM one word at a time. While a
// load is running, the core is held in reset (busy_o) and its fetch path is
// blanked. When the controller is idle, the ROM port is handed to the core
// for instruction fetch.

module rom_boot_ctrl #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned ROM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic [12:0] len_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        byte_rdy_o,
  input  logic [31:0] core_addr_i,
  output logic [31:0] core_data_o,
  output logic        rom_wen_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_wdata_o,
  input  logic [31:0] rom_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Idle counter must be able to hold TIMEOUT-1; the abort fires on the
  // TIMEOUT-th consecutive cycle without an accepted byte.
  localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  // Largest word count that fits in the ROM.
  localparam logic [12:0] MAX_LEN = 13'(ROM_WORDS);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [12:0]       word_cnt_r;
  logic [12:0]       eff_len_r;
  logic [1:0]        byte_cnt_r;
  logic [31:0]       data_buf_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic              err_r;

  logic              accept_s;
  logic              timeout_s;
  logic              last_byte_s;
  logic [12:0]       len_clamp_s;
  logic [12:0]       word_nxt_s;

  // Byte handshake, word-completion and timeout qualifiers
  always_comb begin
    accept_s    = (state_r == ST_LOAD) && byte_vld_i;
    last_byte_s = accept_s && (byte_cnt_r == 2'd3);
    timeout_s   = (state_r == ST_LOAD) && !byte_vld_i && (idle_cnt_r == IDLE_LAST);
    word_nxt_s  = word_cnt_r + 13'd1;
    if (len_i > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = len_i;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (len_clamp_s != 13'd0) begin
            state_nxt_s = ST_LOAD;
          end else begin
            // Zero-length load: report completion without touching the ROM.
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (last_byte_s) begin
          state_nxt_s = ST_WRITE;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (word_nxt_s == eff_len_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and load datapath (synchronous active-low reset)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      word_cnt_r <= 13'd0;
      eff_len_r  <= 13'd0;
      byte_cnt_r <= 2'd0;
      data_buf_r <= 32'd0;
      idle_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            err_r      <= 1'b0;
            word_cnt_r <= 13'd0;
            byte_cnt_r <= 2'd0;
            eff_len_r  <= len_clamp_s;
            idle_cnt_r <= '0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            // Little-endian packing: byte k of the word goes to bits [8k+7:8k].
            data_buf_r[{byte_cnt_r, 3'b000} +: 8] <= byte_i;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            idle_cnt_r <= '0;
          end else if (timeout_s) begin
            // Abort: the partial word is dropped, already written words stay.
            err_r      <= 1'b1;
            byte_cnt_r <= 2'd0;
            idle_cnt_r <= '0;
          end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
          end
        end
        ST_WRITE: begin
          word_cnt_r <= word_nxt_s;
          // Re-entering LOAD starts a fresh idle window.
          idle_cnt_r <= '0;
        end
        ST_DONE: begin
          idle_cnt_r <= '0;
        end
        default: begin
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

  // Output decode; strobes are forced low while rstn is asserted
  always_comb begin
    busy_o      = rstn && (state_r != ST_IDLE);
    byte_rdy_o  = rstn && (state_r == ST_LOAD);
    rom_wen_o   = rstn && (state_r == ST_WRITE);
    done_o      = rstn && (state_r == ST_DONE);
    err_o       = rstn && err_r;
    rom_wdata_o = data_buf_r;
    if (state_r == ST_IDLE) begin
      // Core owns the ROM read port.
      rom_addr_o  = core_addr_i;
      core_data_o = rom_rdata_i;
    end else begin
      // Loader owns the ROM; the core sees zeros while held in reset.
      rom_addr_o  = {17'd0, word_cnt_r, 2'b00};
      core_data_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_rom_boot_ctrl.sv
// Testbench for rom_boot_ctrl: per-cycle vector table for the main load
// flows, plus directed sequences for timeout, mid-load reset and clamping.

module tb_rom_boot_ctrl;

  logic        clk;
  logic        rstn;
  logic        start_i;
  logic [12:0] len_i;
  logic        byte_vld_i;
  logic [7:0]  byte_i;
  logic        byte_rdy_o;
  logic [31:0] core_addr_i;
  logic [31:0] core_data_o;
  logic        rom_wen_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_wdata_o;
  logic [31:0] rom_rdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  rom_boot_ctrl #(.TIMEOUT(8), .ROM_WORDS(4096)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .len_i       (len_i),
    .byte_vld_i  (byte_vld_i),
    .byte_i      (byte_i),
    .byte_rdy_o  (byte_rdy_o),
    .core_addr_i (core_addr_i),
    .core_data_o (core_data_o),
    .rom_wen_o   (rom_wen_o),
    .rom_addr_o  (rom_addr_o),
    .rom_wdata_o (rom_wdata_o),
    .rom_rdata_i (rom_rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model with write log
  logic [31:0] mem [0:4095];
  logic        mem_init_done = 1'b0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_waddr = 32'd0;

  assign rom_rdata_i = mem[rom_addr_o[13:2]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
      mem[2] <= 32'hCAFEF00D;
      mem_init_done <= 1'b1;
    end else if (rom_wen_o) begin
      mem[rom_addr_o[13:2]] <= rom_wdata_o;
    end
    if (rom_wen_o) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= rom_addr_o;
    end
    if (done_o) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic [12:0] len;
    logic        vld;
    logic [7:0]  data;
    logic        rdy;
    logic        wen;
    logic        busy;
    logic        done;
    logic        ca;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cdata;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic st, input logic [12:0] ln, input logic vl,
                            input logic [7:0] d, input logic rdy, input logic wen,
                            input logic busy, input logic done, input logic ca,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] cd);
    vec_t e;
    e.start = st; e.len = ln; e.vld = vl; e.data = d;
    e.rdy = rdy; e.wen = wen; e.busy = busy; e.done = done;
    e.ca = ca; e.addr = a; e.wdata = wd; e.cdata = cd;
    tbl.push_back(e);
  endfunction

  localparam logic [31:0] CF = 32'hCAFEF00D;

  int          n;
  int          wr_before;
  int          done_before;
  logic        done_seen;

  initial begin
    rstn = 1'b0; start_i = 1'b0; len_i = 13'd0; byte_vld_i = 1'b0;
    byte_i = 8'd0; core_addr_i = 32'h8;

    // Two-pass load, len 2, back-to-back bytes
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, CF);
    v(1'b1, 13'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, CF);
    v(1'b0, 13'd0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h44332211, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 32'h88776655, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, CF);
    // Zero-length load
    v(1'b1, 13'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, CF);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, CF);
    // Gapped bytes, len 1; a stray start during LOAD must be ignored
    v(1'b1, 13'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, CF);
    v(1'b0, 13'd0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b1, 13'd3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'hA4A3A2A1, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h0, 32'h0);
    v(1'b0, 13'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, CF);

    // Reset
    step();
    step();
    #3;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rdy", {31'd0, byte_rdy_o}, 32'd0);
    chk("rst_wen", {31'd0, rom_wen_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    step();
    rstn = 1'b1;

    // Vector table
    foreach (tbl[i]) begin
      start_i = tbl[i].start; len_i = tbl[i].len;
      byte_vld_i = tbl[i].vld; byte_i = tbl[i].data;
      #3;
      chk($sformatf("v%0d_rdy", i), {31'd0, byte_rdy_o}, {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d_wen", i), {31'd0, rom_wen_o}, {31'd0, tbl[i].wen});
      chk($sformatf("v%0d_busy", i), {31'd0, busy_o}, {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_done", i), {31'd0, done_o}, {31'd0, tbl[i].done});
      chk($sformatf("v%0d_err", i), {31'd0, err_o}, 32'd0);
      chk($sformatf("v%0d_cdata", i), core_data_o, tbl[i].cdata);
      if (tbl[i].ca) chk($sformatf("v%0d_addr", i), rom_addr_o, tbl[i].addr);
      if (tbl[i].wen) chk($sformatf("v%0d_wdata", i), rom_wdata_o, tbl[i].wdata);
      step();
    end
    start_i = 1'b0; byte_vld_i = 1'b0;
    chk("tbl_writes", wr_cnt, 32'd3);
    chk("tbl_dones", done_cnt, 32'd3);

    // Timeout: 2 bytes then stall with TIMEOUT=8
    wr_before = wr_cnt; done_before = done_cnt;
    start_i = 1'b1; len_i = 13'd1; step();
    start_i = 1'b0; byte_vld_i = 1'b1; byte_i = 8'h5A; step();
    byte_i = 8'hA5; step();
    byte_vld_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #3;
      chk($sformatf("to_busy%0d", k), {31'd0, busy_o}, 32'd1);
      chk($sformatf("to_err%0d", k), {31'd0, err_o}, 32'd0);
      step();
    end
    #3;
    chk("to_err_set", {31'd0, err_o}, 32'd1);
    chk("to_idle", {31'd0, busy_o}, 32'd0);
    chk("to_rdy", {31'd0, byte_rdy_o}, 32'd0);
    chk("to_nowrite", wr_cnt, wr_before);
    chk("to_nodone", done_cnt, done_before);
    step();
    #3;
    chk("to_sticky", {31'd0, err_o}, 32'd1);
    start_i = 1'b1; len_i = 13'd1; step();
    start_i = 1'b0;
    #3;
    chk("to_err_clr", {31'd0, err_o}, 32'd0);
    chk("to_reload", {31'd0, busy_o}, 32'd1);
    byte_vld_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      byte_i = 8'(k);
      step();
    end
    byte_vld_i = 1'b0;
    #3;
    chk("to_wen", {31'd0, rom_wen_o}, 32'd1);
    chk("to_wdata", rom_wdata_o, 32'h04030201);
    step();
    #3;
    chk("to_done", {31'd0, done_o}, 32'd1);
    step();

    // Reset after 3 of 4 bytes
    wr_before = wr_cnt;
    start_i = 1'b1; len_i = 13'd1; step();
    start_i = 1'b0; byte_vld_i = 1'b1;
    byte_i = 8'hE1; step();
    byte_i = 8'hE2; step();
    byte_i = 8'hE3; step();
    byte_vld_i = 1'b0; rstn = 1'b0;
    #3;
    chk("mr_busy", {31'd0, busy_o}, 32'd0);
    chk("mr_rdy", {31'd0, byte_rdy_o}, 32'd0);
    chk("mr_wen", {31'd0, rom_wen_o}, 32'd0);
    chk("mr_done", {31'd0, done_o}, 32'd0);
    step();
    #3;
    chk("mr_busy2", {31'd0, busy_o}, 32'd0);
    chk("mr_wdata", rom_wdata_o, 32'h0);
    step();
    rstn = 1'b1; byte_vld_i = 1'b1; byte_i = 8'hE4;
    for (int k = 0; k < 6; k++) step();
    byte_vld_i = 1'b0;
    #3;
    chk("mr_nowrite", wr_cnt, wr_before);
    chk("mr_idle", {31'd0, busy_o}, 32'd0);
    step();

    // Clamp: len 5000 loads exactly 4096 words at 5 cycles per word
    wr_before = wr_cnt;
    start_i = 1'b1; len_i = 13'd5000; step();
    start_i = 1'b0; byte_vld_i = 1'b1;
    n = 1; done_seen = 1'b0;
    while (!done_seen && n < 25000) begin
      byte_i = n[7:0];
      #3;
      if (done_o) begin
        done_seen = 1'b1;
      end else begin
        step();
        n++;
      end
    end
    byte_vld_i = 1'b0;
    chk("cl_done_cycle", n, 32'd20481);
    chk("cl_writes", wr_cnt - wr_before, 32'd4096);
    chk("cl_last_addr", last_waddr, 32'h3FFC);
    step();
    #3;
    chk("cl_idle", {31'd0, busy_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
